// File: rtl/baccarat_pkg.sv
// Shared types and constants for the baccarat dealing controller.
//   state_t           - controller state encoding
//   NATURAL_MIN_DEF   - default two-card score that ends the hand immediately
//   PLAYER_STAND_MIN  - lowest two-card score on which the player stands
//   SCORE_MAX         - highest legal score value; larger inputs are read as this
package baccarat_pkg;

  localparam int NATURAL_MIN_DEF  = 8;
  localparam int PLAYER_STAND_MIN = 6;
  localparam int SCORE_MAX        = 9;

  typedef enum logic [3:0] {
    S_START = 4'd0,
    S_P1    = 4'd1,
    S_D1    = 4'd2,
    S_P2    = 4'd3,
    S_D2    = 4'd4,
    S_EVAL2 = 4'd5,
    S_P3    = 4'd6,
    S_EVAL3 = 4'd7,
    S_D3    = 4'd8,
    S_DONE  = 4'd9
  } state_t;

endpackage

// File: rtl/banker_draw_rule.sv
// Banker third-card decision once the player has drawn.
//   dscore - banker two-card score, 0..9
//   pcard3 - value of the player's third card, 0..9
//   draw   - 1 when the banker takes a third card
module banker_draw_rule (
  input  logic [3:0] dscore,
  input  logic [3:0] pcard3,
  output logic       draw
);

  always_comb begin
    draw = 1'b0;
    case (dscore)
      4'd0, 4'd1, 4'd2: draw = 1'b1;
      4'd3:             draw = (pcard3 != 4'd8);
      4'd4:             draw = (pcard3 >= 4'd2) && (pcard3 <= 4'd7);
      4'd5:             draw = (pcard3 >= 4'd4) && (pcard3 <= 4'd7);
      4'd6:             draw = (pcard3 >= 4'd6) && (pcard3 <= 4'd7);
      default:          draw = 1'b0;
    endcase
  end

endmodule

// File: rtl/baccarat_ctrl.sv
// Punto Banco dealing controller. Sequences the six card-load strobes into
// the card datapath, applies the third-card rules and drives the win lights.
//
// Ports:
//   slow_clock        - sole clock, rising edge
//   reset             - synchronous, active-high
//   pscore_in         - player score mod 10 from the datapath
//   dscore_in         - dealer score mod 10 from the datapath
//   pcard3_in         - player third-card value
//   step              - (only with BACCARAT_STEP_EN) advance enable
//   load_pcard1..3    - player card load strobes
//   load_dcard1..3    - dealer card load strobes
//   player_win_light  - player wins or tie
//   dealer_win_light  - dealer wins or tie
//
// Build option: define BACCARAT_STEP_EN to single-step the deal with `step`.
//
// state   | meaning
// --------+-------------------------------------------------
// S_START | idle after reset, all outputs low
// S_P1    | load player card 1
// S_D1    | load dealer card 1
// S_P2    | load player card 2
// S_D2    | load dealer card 2
// S_EVAL2 | four-card scores valid: natural / player rule
// S_P3    | load player card 3
// S_EVAL3 | player third card valid: banker rule
// S_D3    | load dealer card 3
// S_DONE  | hand over, lights held until reset
module baccarat_ctrl
  import baccarat_pkg::*;
#(
  parameter int SCORE_W     = 4,
  parameter int NATURAL_MIN = NATURAL_MIN_DEF
) (
  input  logic               slow_clock,
  input  logic               reset,
  input  logic [SCORE_W-1:0] pscore_in,
  input  logic [SCORE_W-1:0] dscore_in,
  input  logic [SCORE_W-1:0] pcard3_in,
`ifdef BACCARAT_STEP_EN
  input  logic               step,
`endif
  output logic               load_pcard1,
  output logic               load_pcard2,
  output logic               load_pcard3,
  output logic               load_dcard1,
  output logic               load_dcard2,
  output logic               load_dcard3,
  output logic               player_win_light,
  output logic               dealer_win_light
);

  state_t     state;
  state_t     nxt;
  logic       advance;
  logic       banker_draw;
  logic [3:0] p_s;
  logic [3:0] d_s;
  logic [3:0] c3_s;
  // {p1, p2, p3, d1, d2, d3}
  logic [5:0] load_q;
  logic [5:0] load_nxt;
  logic       lights_set;
  logic       capture;

  // Out-of-range scores are read as 9, which makes them naturals.
  assign p_s  = (pscore_in > SCORE_W'(SCORE_MAX)) ? 4'(SCORE_MAX) : 4'(pscore_in);
  assign d_s  = (dscore_in > SCORE_W'(SCORE_MAX)) ? 4'(SCORE_MAX) : 4'(dscore_in);
  assign c3_s = (pcard3_in > SCORE_W'(SCORE_MAX)) ? 4'(SCORE_MAX) : 4'(pcard3_in);

`ifdef BACCARAT_STEP_EN
  assign advance = step;
`else
  assign advance = 1'b1;
`endif

  banker_draw_rule u_banker (
    .dscore (d_s),
    .pcard3 (c3_s),
    .draw   (banker_draw)
  );

  always_comb begin
    nxt = state;
    if (advance) begin
      case (state)
        S_START: nxt = S_P1;
        S_P1:    nxt = S_D1;
        S_D1:    nxt = S_P2;
        S_P2:    nxt = S_D2;
        S_D2:    nxt = S_EVAL2;
        S_EVAL2: begin
          if ((p_s >= 4'(NATURAL_MIN)) || (d_s >= 4'(NATURAL_MIN)))
            nxt = S_DONE;
          else if (p_s < 4'(PLAYER_STAND_MIN))
            nxt = S_P3;
          else if (d_s < 4'(PLAYER_STAND_MIN))
            nxt = S_D3;
          else
            nxt = S_DONE;
        end
        S_P3:    nxt = S_EVAL3;
        S_EVAL3: nxt = banker_draw ? S_D3 : S_DONE;
        S_D3:    nxt = S_DONE;
        S_DONE:  nxt = S_DONE;
        default: nxt = S_START;
      endcase
    end
  end

  always_comb begin
    load_nxt = 6'b000000;
    case (nxt)
      S_P1:    load_nxt = 6'b100000;
      S_P2:    load_nxt = 6'b010000;
      S_P3:    load_nxt = 6'b001000;
      S_D1:    load_nxt = 6'b000100;
      S_D2:    load_nxt = 6'b000010;
      S_D3:    load_nxt = 6'b000001;
      default: load_nxt = 6'b000000;
    endcase
  end

  // Leaving an evaluation state, both scores are already final. Leaving S_D3,
  // the dealer's third card only shows up in dscore during the first S_DONE
  // cycle, so in that case the lights are captured one cycle later.
  assign capture = ((nxt == S_DONE) && ((state == S_EVAL2) || (state == S_EVAL3)))
                || ((state == S_DONE) && !lights_set);

  always_ff @(posedge slow_clock) begin
    if (reset) begin
      state            <= S_START;
      load_q           <= 6'b000000;
      player_win_light <= 1'b0;
      dealer_win_light <= 1'b0;
      lights_set       <= 1'b0;
    end else begin
      state  <= nxt;
      load_q <= load_nxt;
      if (capture) begin
        player_win_light <= (p_s >= d_s);
        dealer_win_light <= (d_s >= p_s);
        lights_set       <= 1'b1;
      end
    end
  end

`ifdef BACCARAT_STEP_EN
  // Gating with step keeps one load per press while the state is held.
  assign load_pcard1 = load_q[5] & step;
  assign load_pcard2 = load_q[4] & step;
  assign load_pcard3 = load_q[3] & step;
  assign load_dcard1 = load_q[2] & step;
  assign load_dcard2 = load_q[1] & step;
  assign load_dcard3 = load_q[0] & step;
`else
  assign load_pcard1 = load_q[5];
  assign load_pcard2 = load_q[4];
  assign load_pcard3 = load_q[3];
  assign load_dcard1 = load_q[2];
  assign load_dcard2 = load_q[1];
  assign load_dcard3 = load_q[0];
`endif

endmodule
